phv_reassembler: RTL

Recombines ALU results and untouched metadata back into a full PHV at the end of the action stage. It sits downstream of the crossbar and ALU arrays. The block absorbs per-group ALU latency skew with in-order FIFOs, then emits one PHV per cycle through a valid/ready output register. It also gives the crossbar a credit-style `in_ready`.

---
 rtl/phv_reassembler_if.sv | 50 +++++
 rtl/phv_reassembler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/phv_reassembler_if.sv
`default_nettype none
// ============================================================================
// Module   : phv_reassembler_if
// Purpose  : Bundles the crossbar/ALU-side write strobes and data, the credit
//            signal back upstream, and the PHV output handshake of the
//            PHV reassembler.
// Ports    : master - upstream/downstream side (drives groups and ready)
//            slave  - reassembler side (drives in_ready, phv_out*, err)
// Revision : 1.0 - initial release
// ============================================================================
interface phv_reassembler_if #(
  parameter int PHV_LEN    = 1124,
  parameter int width_6B   = 48,
  parameter int width_4B   = 32,
  parameter int width_2B   = 16,
  parameter int REMAIN_LEN = 356
);
  logic [REMAIN_LEN-1:0]   remain_in;
  logic                    remain_in_valid;
  logic [8*width_6B-1:0]   alu_6B_out;
  logic                    alu_6B_valid;
  logic [8*width_4B-1:0]   alu_4B_out;
  logic                    alu_4B_valid;
  logic [8*width_2B-1:0]   alu_2B_out;
  logic                    alu_2B_valid;
  logic                    in_ready;
  logic [PHV_LEN-1:0]      phv_out;
  logic                    phv_out_valid;
  logic                    phv_out_ready;
  logic                    err_overflow;

  modport master (
    output remain_in, remain_in_valid,
    output alu_6B_out, alu_6B_valid,
    output alu_4B_out, alu_4B_valid,
    output alu_2B_out, alu_2B_valid,
    output phv_out_ready,
    input  in_ready, phv_out, phv_out_valid, err_overflow
  );

  modport slave (
    input  remain_in, remain_in_valid,
    input  alu_6B_out, alu_6B_valid,
    input  alu_4B_out, alu_4B_valid,
    input  alu_2B_out, alu_2B_valid,
    input  phv_out_ready,
    output in_ready, phv_out, phv_out_valid, err_overflow
  );
endinterface
`default_nettype wire

// File: rtl/phv_reassembler.sv
`default_nettype none
// ============================================================================
// Module   : phv_reassembler
// Purpose  : Rebuilds a full PHV from the 6B/4B/2B ALU result groups and the
//            untouched metadata tail. Each group lands in its own in-order
//            FIFO so arbitrary per-group latency skew is absorbed; once every
//            FIFO holds an entry, one PHV is popped into a valid/ready output
//            register.
// Ports    : clk            - single clock
//            rst_n          - synchronous active-low reset
//            bus (slave)    - group data/strobes, in_ready credit,
//                             phv_out/phv_out_valid/phv_out_ready,
//                             sticky err_overflow
// Revision : 1.0 - initial release
// ============================================================================
module phv_reassembler #(
  parameter int STAGE_ID   = 0,
  parameter int PHV_LEN    = 1124,
  parameter int width_6B   = 48,
  parameter int width_4B   = 32,
  parameter int width_2B   = 16,
  parameter int REMAIN_LEN = 356,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  phv_reassembler_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // FIFO index: 0 = remain, 1 = 2B, 2 = 4B, 3 = 6B. This ordering makes the
  // concatenated write/read vectors line up bit-for-bit with the PHV layout.
  logic [PHV_LEN-1:0] w_wr_data;
  logic [PHV_LEN-1:0] w_rd_data;
  logic [3:0]         w_wr_en;
  logic [3:0]         w_empty;
  logic [3:0]         w_full;
  logic [3:0]         w_ovf;
  logic               w_pop;

  logic [PW-1:0]      rd_ptr_q;
  logic [PHV_LEN-1:0] phv_q;
  logic               valid_q;
  logic               err_q;

  if ((PHV_LEN != 8*width_6B + 8*width_4B + 8*width_2B + REMAIN_LEN) ||
      (STAGE_ID < 0) || (FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_err
    $error("phv_reassembler: inconsistent parameters");
  end

  assign w_wr_data = {bus.alu_6B_out, bus.alu_4B_out, bus.alu_2B_out, bus.remain_in};
  // Strobes are masked during reset so nothing is written into the storage.
  assign w_wr_en   = rst_n ? {bus.alu_6B_valid, bus.alu_4B_valid,
                              bus.alu_2B_valid, bus.remain_in_valid} : 4'b0000;

  assign w_pop = (w_empty == 4'b0000) && (!valid_q || bus.phv_out_ready);

  // All FIFOs pop together, so one shared read pointer serves all four.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
    localparam int W   = (gi == 0) ? REMAIN_LEN :
                         (gi == 1) ? 8*width_2B :
                         (gi == 2) ? 8*width_4B : 8*width_6B;
    localparam int OFF = (gi == 0) ? 0 :
                         (gi == 1) ? REMAIN_LEN :
                         (gi == 2) ? REMAIN_LEN + 8*width_2B :
                                     REMAIN_LEN + 8*width_2B + 8*width_4B;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wr_acc;

    assign w_full[gi]  = (cnt_q == CW'(FIFO_DEPTH));
    assign w_empty[gi] = (cnt_q == '0);
    // A simultaneous pop frees the slot the write lands in.
    assign wr_acc      = w_wr_en[gi] && (!w_full[gi] || w_pop);
    assign w_ovf[gi]   = w_wr_en[gi] && w_full[gi] && !w_pop;

    always_comb begin
      cnt_d = cnt_q;
      if (wr_acc && !w_pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!wr_acc && w_pop) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (wr_acc) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (wr_acc) begin
        mem_q[wr_ptr_q] <= w_wr_data[OFF +: W];
      end
    end

    assign w_rd_data[OFF +: W] = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      phv_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        phv_q    <= w_rd_data;
        valid_q  <= 1'b1;
      end else if (bus.phv_out_ready) begin
        valid_q  <= 1'b0;
      end
      if (|w_ovf) begin
        err_q <= 1'b1;
      end
    end
  end

  // Only the remain FIFO gates upstream: every ALU group entry is paired
  // with a remain entry, so the ALU FIFOs can never run ahead of it.
  assign bus.in_ready      = rst_n && !w_full[0];
  assign bus.phv_out       = phv_q;
  assign bus.phv_out_valid = valid_q;
  assign bus.err_overflow  = err_q;

endmodule
`default_nettype wire
